// File: rtl/reg_bus_pkg.sv
// Shared types for the register-bus arbiter: sequencer states, default bus widths
// and the latched command record.
package reg_bus_pkg;

    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } bus_state_t;

    // Field widths follow the package defaults; the top uses them for its bus widths too.
    typedef struct packed {
        logic                  write;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wdata;
    } reg_cmd_t;

endpackage

// File: rtl/reg_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or above ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + (IDX_W+1)'(off);
        if (s >= (IDX_W+1)'(N))
            s = s - (IDX_W+1)'(N);
        return s[IDX_W-1:0];
    endfunction

    // Walk from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)])
                winner = wrap_idx(ptr, k);
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register bus among N_REQ requesters: round-robin grant, one-cycle bus
// issue, fixed read latency wait, then a one-cycle acknowledge to the owner.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int DATA_W       = REG_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                bus_sel,
    output logic                write,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W-1:0]   data_out
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = 2;

    bus_state_t          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    reg_cmd_t            cmd_q, cmd_d;

    logic [IDX_W-1:0]    winner;
    logic                any_req;
    logic [N_REQ-1:0]    owner_1h;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        cmd_d   = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d       = winner;
                    cmd_d.write   = req_write[winner];
                    cmd_d.addr    = req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    cmd_d.wdata   = req_wdata[int'(winner)*DATA_W +: DATA_W];
                    ptr_d         = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_q.write) begin
                    state_d = ST_RESP;
                end else begin
                    wait_d  = CNT_W'(READ_LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    rdata_d = data_out;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode only registered state, so req never reaches an output combinationally.
    assign owner_1h = N_REQ'(1) << owner_q;
    assign bus_sel  = (state_q == ST_ISSUE);
    assign write    = bus_sel & cmd_q.write;
    assign address  = bus_sel ? cmd_q.addr  : '0;
    assign data_in  = bus_sel ? cmd_q.wdata : '0;
    assign gnt      = bus_sel ? owner_1h : '0;
    assign ack      = (state_q == ST_RESP) ? owner_1h : '0;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Randomized and directed bench for reg_bus_arbiter against a transaction-timeline
// reference model.
module tb_reg_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RL = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req, req_write, gnt, ack;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rdata, data_in, data_out;
    logic            bus_sel, write;
    logic [AW-1:0]   address;

    reg_bus_arbiter #(
        .N_REQ        (N),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .bus_sel   (bus_sel),
        .write     (write),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    // Slave: read data is valid only during the single cycle ending RL edges after the issue edge.
    logic [DW-1:0] mem [256];
    int            sl_left = -1;
    logic [AW-1:0] sl_addr = '0;

    initial begin
        data_out = '0;
        forever begin
            @(negedge clk);
            if (rst)
                sl_left = -1;
            else if (bus_sel && !write) begin
                sl_left = RL;
                sl_addr = address;
            end
            @(posedge clk);
            #1;
            if (sl_left >= 0)
                sl_left--;
            data_out = (sl_left == 0) ? mem[sl_addr] : DW'($urandom);
        end
    end

    // Requesters
    logic          p_pend [N];
    logic          p_wr   [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_wd   [N];
    logic [N-1:0]  gnt_seen = '0;

    task automatic issue(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_pend[i] = 1'b1;
        p_wr[i]   = wr;
        p_addr[i] = a;
        p_wd[i]   = d;
    endtask

    task automatic drive_reqs(input int prob);
        for (int i = 0; i < N; i++) begin
            if (gnt_seen[i]) begin
                p_pend[i] = 1'b0;
                p_wr[i]   = 1'($urandom);
                p_addr[i] = AW'($urandom);
                p_wd[i]   = DW'($urandom);
            end
            if (!p_pend[i] && prob > 0 && $urandom_range(99) < prob)
                issue(i, 1'($urandom), AW'($urandom), DW'($urandom));
            req[i]                = p_pend[i];
            req_write[i]          = p_wr[i];
            req_addr[i*AW +: AW]  = p_addr[i];
            req_wdata[i*DW +: DW] = p_wd[i];
        end
    endtask

    // Reference model: one transaction at a time, scheduled by cycle number.
    int            m_ptr   = 0;
    int            m_free  = 0;
    int            t_gnt   = -1;
    int            t_ack   = -1;
    int            m_owner = 0;
    logic          m_wr    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wd    = '0;
    logic [DW-1:0] m_rdata = '0;

    task automatic model_reset();
        m_ptr   = 0;
        t_gnt   = -1;
        t_ack   = -1;
        m_rdata = '0;
        for (int i = 0; i < N; i++) p_pend[i] = 1'b0;
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_g, exp_a;
        exp_g = (cyc == t_gnt) ? N'(1) << m_owner : '0;
        exp_a = (cyc == t_ack) ? N'(1) << m_owner : '0;
        chk("gnt", 32'(gnt), 32'(exp_g));
        chk("bus_sel", 32'(bus_sel), 32'(cyc == t_gnt));
        if (cyc == t_gnt) begin
            chk("write", 32'(write), 32'(m_wr));
            chk("address", 32'(address), 32'(m_addr));
            if (m_wr)
                chk("data_in", 32'(data_in), 32'(m_wd));
        end
        if (cyc == t_ack && !m_wr)
            m_rdata = mem[m_addr];
        chk("ack", 32'(ack), 32'(exp_a));
        chk("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic model_arb();
        int w;
        bit found;
        found = 0;
        w     = 0;
        if (!rst && cyc >= m_free && |req) begin
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    w     = (m_ptr + k) % N;
                    found = 1;
                end
            end
            m_owner = w;
            m_wr    = req_write[w];
            m_addr  = req_addr[w*AW +: AW];
            m_wd    = req_wdata[w*DW +: DW];
            t_gnt   = cyc + 1;
            t_ack   = m_wr ? cyc + 2 : cyc + 2 + RL;
            m_free  = t_ack + 1;
            m_ptr   = (w + 1) % N;
        end
    endtask

    task automatic run_cycle(input int prob);
        drive_reqs(prob);
        @(negedge clk);
        gnt_seen = gnt;
        check_outputs();
        model_arb();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_all_zero();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_data_in", 32'(data_in), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        gnt_seen = '0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int budget;
        for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
        mem[8'h20] = 16'h1234;
        for (int i = 0; i < N; i++) begin
            p_pend[i] = 1'b0;
            p_wr[i]   = 1'b0;
            p_addr[i] = '0;
            p_wd[i]   = '0;
        end
        drive_reqs(0);

        @(posedge clk);
        #1;
        chk_all_zero();
        chk_all_zero();
        rst    = 1'b0;
        m_free = cyc;

        // Single write from requester 2; rr_ptr moves to 3.
        issue(2, 1'b1, 8'h10, 16'h00A5);
        repeat (6) run_cycle(0);

        // 3 and 0 together with rr_ptr=3: 3 first, then 0, leaving rr_ptr=1.
        issue(3, 1'b1, 8'h33, 16'hBEEF);
        issue(0, 1'b0, 8'h40, 16'h0000);
        repeat (14) run_cycle(0);
        issue(0, 1'b1, 8'h01, 16'h1111);
        issue(1, 1'b1, 8'h02, 16'h2222);
        issue(2, 1'b0, 8'h03, 16'h3333);
        repeat (20) run_cycle(0);

        // Read with the slave answering 16'h1234 at address 8'h20.
        issue(1, 1'b0, 8'h20, 16'hFFFF);
        repeat (8) run_cycle(0);

        // All requesters continuously active: strict rotation.
        repeat (60) run_cycle(100);
        repeat (40) run_cycle(0);

        // Reset during the WAIT phase of a read.
        issue(1, 1'b0, 8'h20, 16'h0000);
        budget = 20;
        while (!(t_gnt >= 0 && cyc == t_gnt + 1 && !m_wr) && budget > 0) begin
            run_cycle(0);
            budget--;
        end
        chk("reach_wait", 32'(budget > 0), 32'd1);
        rst = 1'b1;
        model_reset();
        drive_reqs(0);
        chk_all_zero();
        chk_all_zero();
        rst    = 1'b0;
        m_free = cyc;
        issue(1, 1'b1, 8'h55, 16'hA5A5);
        issue(3, 1'b0, 8'h20, 16'h0000);
        repeat (16) run_cycle(0);

        // Randomized traffic.
        repeat (2000) run_cycle(30);
        repeat (60) run_cycle(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
